// File: rtl/sreg_pkg.sv
// Shared definitions for the special-register write decoder and storage:
// register codes, code-to-write-bit mapping, register count, default width.
package sreg_pkg;

    localparam int unsigned SREG_NUM    = 8;
    localparam int unsigned SREG_DATA_W = 16;

    typedef enum logic [3:0] {
        SREG_NONE     = 4'd0,
        SREG_RCOL     = 4'd1,
        SREG_RROW     = 4'd2,
        SREG_RI       = 4'd3,
        SREG_RJ       = 4'd4,
        SREG_RTOTAL   = 4'd5,
        SREG_RADDRESS = 4'd6,
        SREG_RBND     = 4'd7,
        SREG_RCOLTEMP = 4'd8
    } sreg_code_e;

    // Storage index (code - 1) of the registers the top module taps directly
    localparam int unsigned SREG_IDX_RI       = 2;
    localparam int unsigned SREG_IDX_RADDRESS = 5;
    localparam int unsigned SREG_IDX_RBND     = 6;

    // True for codes that name a real register (1..8)
    function automatic logic sreg_code_valid(input logic [3:0] c);
        return (c >= SREG_RCOL) && (c <= SREG_RCOLTEMP);
    endfunction

    // Storage index of a valid code
    function automatic logic [2:0] sreg_code_to_idx(input logic [3:0] c);
        logic [3:0] t;
        t = c - 4'd1;
        return t[2:0];
    endfunction

    // wr_en bit carrying a code: Rcol is bit 7 down to RcolTemp at bit 0
    function automatic int unsigned sreg_wr_bit(input logic [3:0] c);
        return SREG_NUM - 32'(c);
    endfunction

endpackage

// File: rtl/sreg_cell.sv
// One special register with write > clear > increment > hold priority.
// o_d exposes the value the register takes at the next edge.
module sreg_cell #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [DATA_W-1:0] o_q,
    output logic [DATA_W-1:0] o_d
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_d;

    // Next-value selection; increment wraps naturally at 2^DATA_W
    always_comb begin
        w_d = r_q;
        if (i_wr)
            w_d = i_wr_data;
        else if (i_clr)
            w_d = '0;
        else if (i_inc)
            w_d = r_q + DATA_W'(1);
    end

    // Register storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else
            r_q <= w_d;
    end

    assign o_q = r_q;
    assign o_d = w_d;

endmodule

// File: rtl/special_register_file.sv
// Eight special-purpose registers with registered read-back, live Raddress
// output and a registered Ri == Rbnd flag.
// Optional: define SREG_ONEHOT_CHECK_EN to enable the sticky onehot_err flag
// for write vectors with more than one bit set; otherwise onehot_err is 0.
module special_register_file
    import sreg_pkg::*;
#(
    parameter int unsigned DATA_W = SREG_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        clr_sel,
    input  logic [3:0]        inc_sel,
    input  logic [3:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] raddress,
    output logic              i_eq_bnd,
    output logic              onehot_err
);

    logic [DATA_W-1:0] w_q [SREG_NUM];
    logic [DATA_W-1:0] w_d [SREG_NUM];
    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_eq_bnd;

    for (genvar g = 0; g < SREG_NUM; g++) begin : g_cell
        localparam logic [3:0]  L_CODE = 4'(g + 1);
        localparam int unsigned L_BIT  = sreg_wr_bit(L_CODE);

        sreg_cell #(
            .DATA_W(DATA_W)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .i_wr      (wr_en[L_BIT]),
            .i_wr_data (wr_data),
            .i_clr     (clr_sel == L_CODE),
            .i_inc     (inc_sel == L_CODE),
            .o_q       (w_q[g]),
            .o_d       (w_d[g])
        );
    end

    // Read mux over current contents; unused codes read as zero
    always_comb begin
        w_rd_mux = '0;
        if (sreg_code_valid(rd_sel))
            w_rd_mux = w_q[sreg_code_to_idx(rd_sel)];
    end

    // Read-back and loop-bound flag; the flag compares post-update values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_eq_bnd  <= 1'b0;
        end else begin
            r_rd_data <= w_rd_mux;
            r_eq_bnd  <= (w_d[SREG_IDX_RI] == w_d[SREG_IDX_RBND]);
        end
    end

`ifdef SREG_ONEHOT_CHECK_EN
    logic r_onehot_err;

    // Sticky flag for write vectors with more than one bit set
    always_ff @(posedge clk) begin
        if (rst)
            r_onehot_err <= 1'b0;
        else if ((wr_en & (wr_en - 8'd1)) != 8'd0)
            r_onehot_err <= 1'b1;
    end

    assign onehot_err = r_onehot_err;
`else
    assign onehot_err = 1'b0;
`endif

    assign rd_data  = r_rd_data;
    assign raddress = w_q[SREG_IDX_RADDRESS];
    assign i_eq_bnd = r_eq_bnd;

endmodule

// File: tb/tb_special_register_file.sv
// Self-checking bench for special_register_file: directed steps followed by
// randomized traffic, checked against an array-based reference model.
module tb_special_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wr_en;
    logic [15:0] wr_data;
    logic [3:0]  clr_sel;
    logic [3:0]  inc_sel;
    logic [3:0]  rd_sel;
    logic [15:0] rd_data;
    logic [15:0] raddress;
    logic        i_eq_bnd;
    logic        onehot_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state: index k holds the register with code k+1
    logic [15:0] m [8];
    logic [15:0] exp_rd;
    logic        exp_flag;
    logic        exp_err;

    special_register_file #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_sel    (clr_sel),
        .inc_sel    (inc_sel),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .raddress   (raddress),
        .i_eq_bnd   (i_eq_bnd),
        .onehot_err (onehot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs
    task automatic step(input logic r, input logic [7:0] we, input logic [15:0] wd,
                        input logic [3:0] cs, input logic [3:0] is, input logic [3:0] rs);
        logic [15:0] nm [8];
        rst = r; wr_en = we; wr_data = wd; clr_sel = cs; inc_sel = is; rd_sel = rs;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 8; k++) m[k] = 16'h0;
            exp_rd = 16'h0; exp_flag = 1'b0; exp_err = 1'b0;
        end else begin
            exp_rd = (rs >= 1 && rs <= 8) ? m[int'(rs) - 1] : 16'h0;
            for (int k = 0; k < 8; k++) begin
                if (we[7 - k])            nm[k] = wd;
                else if (int'(cs) == k+1) nm[k] = 16'h0;
                else if (int'(is) == k+1) nm[k] = m[k] + 16'h1;
                else                      nm[k] = m[k];
            end
            for (int k = 0; k < 8; k++) m[k] = nm[k];
            exp_flag = (m[2] == m[6]);
`ifdef SREG_ONEHOT_CHECK_EN
            if ($countones(we) > 1) exp_err = 1'b1;
`endif
        end
        chk("rd_data", rd_data, exp_rd);
        chk("raddress", raddress, m[5]);
        chk("i_eq_bnd", {15'h0, i_eq_bnd}, {15'h0, exp_flag});
        chk("onehot_err", {15'h0, onehot_err}, {15'h0, exp_err});
    endtask

    initial begin
        logic        exp_oh;
        logic [7:0]  we;
        logic [15:0] wd;
        int unsigned sel;
`ifdef SREG_ONEHOT_CHECK_EN
        exp_oh = 1'b1;
`else
        exp_oh = 1'b0;
`endif
        for (int k = 0; k < 8; k++) m[k] = 16'h0;
        exp_rd = '0; exp_flag = 1'b0; exp_err = 1'b0;

        // Reset and read every register
        step(1'b1, 8'h00, 16'hDEAD, 4'd0, 4'd0, 4'd0);
        chk("reset_flag", {15'h0, i_eq_bnd}, 16'h0);
        chk("reset_raddr", raddress, 16'h0);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'(c));
            chk("reset_read", rd_data, 16'h0);
        end

        // Write Ri, read in the same cycle (old value) and the next
        step(1'b0, 8'h20, 16'h0123, 4'd0, 4'd0, 4'd3);
        chk("ri_same_cycle", rd_data, 16'h0000);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd3);
        chk("ri_read", rd_data, 16'h0123);

        // Write beats clear beats increment
        step(1'b0, 8'h10, 16'h0005, 4'd0, 4'd0, 4'd0);
        step(1'b0, 8'h10, 16'h0AAA, 4'd4, 4'd4, 4'd4);
        chk("rj_pre", rd_data, 16'h0005);
        step(1'b0, 8'h00, 16'h0, 4'd4, 4'd4, 4'd4);
        chk("rj_write_prio", rd_data, 16'h0AAA);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd4);
        chk("rj_clear_prio", rd_data, 16'h0000);

        // Increment wrap
        step(1'b0, 8'h20, 16'hFFFF, 4'd0, 4'd0, 4'd0);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd3, 4'd3);
        chk("ri_full", rd_data, 16'hFFFF);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd3);
        chk("ri_wrap", rd_data, 16'h0000);

        // Loop-bound flag follows increments with no extra delay
        step(1'b0, 8'h02, 16'h0003, 4'd0, 4'd0, 4'd0);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd3, 4'd0);
        chk("flag_inc1", {15'h0, i_eq_bnd}, 16'h0);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd3, 4'd0);
        chk("flag_inc2", {15'h0, i_eq_bnd}, 16'h0);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd3, 4'd0);
        chk("flag_inc3", {15'h0, i_eq_bnd}, 16'h1);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd3, 4'd0);
        chk("flag_inc4", {15'h0, i_eq_bnd}, 16'h0);

        // Address path
        step(1'b0, 8'h04, 16'h0100, 4'd0, 4'd0, 4'd0);
        chk("raddr_write", raddress, 16'h0100);
        for (int n = 1; n <= 4; n++) begin
            step(1'b0, 8'h00, 16'h0, 4'd0, 4'd6, 4'd0);
            chk("raddr_inc", raddress, 16'h0100 + 16'(n));
        end

        // Broadcast write and the optional error flag
        step(1'b0, 8'h81, 16'h0077, 4'd0, 4'd0, 4'd0);
        chk("onehot_set", {15'h0, onehot_err}, {15'h0, exp_oh});
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd1);
        chk("bcast_rcol", rd_data, 16'h0077);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd8);
        chk("bcast_rcoltemp", rd_data, 16'h0077);
        chk("onehot_sticky", {15'h0, onehot_err}, {15'h0, exp_oh});
        step(1'b1, 8'hFF, 16'h1234, 4'd3, 4'd5, 4'd1);
        chk("onehot_reset", {15'h0, onehot_err}, 16'h0);
        step(1'b0, 8'h00, 16'h0, 4'd0, 4'd0, 4'd1);
        chk("reset_discard", rd_data, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      we = 8'h00;
            else if (sel < 8) we = 8'h01 << $urandom_range(0, 7);
            else              we = 8'($urandom);
            wd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            step(($urandom_range(0, 59) == 0), we, wd,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/special_register_file.md
Name: special_register_file

Overview:
- Storage stage directly downstream of the special-register write decoder.
- Holds the eight special-purpose registers: Rcol, Rrow, Ri, Rj, Rtotal, Raddress, Rbnd, RcolTemp.
- Each register is written from the datapath bus under the decoder's one-hot write vector, and can also be cleared or incremented by the control unit.
- Returns a registered read-back value to the bus, drives the memory address, and produces a registered loop-bound flag.

Parameters:
- DATA_W, 16, width of every special register and of the bus data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  8  one-hot write vector from the decoder. Bit 7 = Rcol, 6 = Rrow, 5 = Ri, 4 = Rj, 3 = Rtotal, 2 = Raddress, 1 = Rbnd, 0 = RcolTemp.
- wr_data  input  DATA_W  bus value written to the selected register(s).
- clr_sel  input  4  register code to clear to 0.
- inc_sel  input  4  register code to increment by 1.
- rd_sel  input  4  register code to read back.
- rd_data  output  DATA_W  registered read-back value.
- raddress  output  DATA_W  live Raddress contents, for the memory address port.
- i_eq_bnd  output  1  registered flag: Ri == Rbnd.
- onehot_err  output  1  sticky write-vector error (optional feature only).

Behaviour:
- Register codes: 1 Rcol, 2 Rrow, 3 Ri, 4 Rj, 5 Rtotal, 6 Raddress, 7 Rbnd, 8 RcolTemp.
- Codes 0 and 9–15 are no-ops for clr_sel and inc_sel; for rd_sel they yield rd_data = 0.
- Reset: when rst is high at a clock edge, all eight registers, rd_data, i_eq_bnd and onehot_err go to 0. Reset overrides every other input that cycle.
- Per-register priority each cycle (highest first):
  - write, when its wr_en bit = 1: reg <= wr_data;
  - else clear, when clr_sel = its code: reg <= 0;
  - else increment, when inc_sel = its code: reg <= reg + 1, modulo 2^DATA_W;
  - else hold.
- All-ones + increment wraps to 0 with no carry or flag.
- Multiple wr_en bits set: every flagged register is written with wr_data (broadcast). No register is corrupted.
- clr_sel and inc_sel may target different registers in the same cycle; both take effect.
- Read latency is 1 cycle: rd_data at edge t+1 = contents of register rd_sel as held during cycle t, i.e. the pre-update value.
  - A write and a read of the same register in one cycle returns the old value.
  - The new value is visible one cycle later.
- raddress is a combinational view of the Raddress flop (0-cycle from register output).
- i_eq_bnd is registered from the post-update values: it becomes 1 on the edge at which the new Ri equals the new Rbnd. It therefore tracks increments with no extra delay.
- No internal FSM beyond per-register update logic and the registered read/flag pipeline.
- Reset mid-operation discards pending updates; no partial writes survive.

Optional Feature:
- Macro: SREG_ONEHOT_CHECK_EN.
- Defined:
  - onehot_err sets on any clock edge where wr_en has more than one bit set.
  - It is sticky until rst.
  - Write behaviour is unchanged (broadcast still occurs).
- Undefined: the check logic is absent and onehot_err is tied to 0.

Decomposition:
- Package sreg_pkg:
  - the eight 4-bit register codes;
  - the code-to-wr_en-bit-index mapping;
  - the register count constant (8);
  - the default DATA_W.
- The decoder and this block both import it.
- One natural sub-module, sreg_cell: a single DATA_W register with the write/clear/increment priority, instantiated 8 times.
- Read mux, flag and error logic stay in the top module.

Test Plan:
- Reset: after rst pulse, read codes 1–8 in turn -> rd_data = 0 every time; i_eq_bnd = 0; raddress = 0.
- Write/read: wr_en = 8'b0010_0000, wr_data = 16'h0123, then rd_sel = 3 -> rd_data = 16'h0123 one cycle after the read request. Same-cycle read of Ri returns the old value 0.
- Priority: Rj = 16'h0005; in one cycle apply wr_en bit 4 with wr_data = 16'h0AAA, clr_sel = 4, inc_sel = 4 -> Rj = 16'h0AAA. Next cycle apply clr_sel = 4 and inc_sel = 4 -> Rj = 0.
- Wrap and flag:
  - Ri = 16'hFFFF, inc_sel = 3 -> Ri = 0.
  - Rbnd = 3, then increment Ri from 0 three times -> i_eq_bnd = 1 on the third increment edge.
  - One more increment -> i_eq_bnd = 0.
- Address path: write Raddress = 16'h0100, inc_sel = 6 for 4 cycles -> raddress = 16'h0101, 0102, 0103, 0104 on successive edges.
- One-hot check (macro defined): wr_en = 8'b1000_0001, wr_data = 16'h0077 -> Rcol = RcolTemp = 16'h0077 and onehot_err = 1, staying set until rst. Without the macro, onehot_err stays 0.
